// File: rtl/mem_stage_dmem_pkg.sv
// Shared definitions for the MEM-stage data block: MMIO offsets, the
// default peripheral window base, TCON bit positions and the RAM decode.
package mem_stage_dmem_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h4000_0000;

  // Byte offsets from the peripheral window base
  localparam logic [31:0] OFF_TH      = 32'h00;
  localparam logic [31:0] OFF_TL      = 32'h04;
  localparam logic [31:0] OFF_TCON    = 32'h08;
  localparam logic [31:0] OFF_LED     = 32'h0C;
  localparam logic [31:0] OFF_DIGI    = 32'h10;
  localparam logic [31:0] OFF_SYSTICK = 32'h14;

  // TCON bits: enable, interrupt enable, interrupt status
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // RAM occupies byte addresses [0, depth*4)
  function automatic logic ram_hit(input logic [31:0] a, input int unsigned depth);
    return a < (depth << 2);
  endfunction

endpackage

// File: rtl/mem_stage_dmem_timer.sv
// mmio_timer: TH/TL reload timer with overflow interrupt, plus a free-running
// SYSTICK counter. Owns the CPU-vs-timer write collision rules.
// Ports: clk, reset (sync, active high); we_th_i/we_tl_i/we_tcon_i per-register
// write strobes with wdata_i; th_o/tl_o/tcon_o/systick_o register values;
// irq_o = TCON.IE & TCON.IS.
module mmio_timer
  import mem_stage_dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_th_i,
  input  logic        we_tl_i,
  input  logic        we_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic [31:0] systick_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d, tl_q, tl_d, systick_q, systick_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf, set_is;

  always_comb begin
    ovf    = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
    set_is = ovf && tcon_q[TCON_IE];

    th_d = we_th_i ? wdata_i : th_q;

    tl_d = tl_q;
    if (tcon_q[TCON_EN]) tl_d = ovf ? th_q : tl_q + 32'd1;
    if (we_tl_i)         tl_d = wdata_i;          // CPU beats the timer

    tcon_d = tcon_q;
    if (set_is) tcon_d[TCON_IS] = 1'b1;
    // A same-cycle overflow still sets IS so the event is never dropped
    if (we_tcon_i) tcon_d = {wdata_i[2] | set_is, wdata_i[1:0]};

    systick_d = systick_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
    end
  end

  assign th_o      = th_q;
  assign tl_o      = tl_q;
  assign tcon_o    = tcon_q;
  assign systick_o = systick_q;
  assign irq_o     = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem: MEM-stage data memory. Word RAM plus an MMIO window
// (timer, LED, 7-seg, systick). Load data is registered so it lines up with
// the MEM/WB register.
// Ports: clk, reset (sync, active high); mem_read/mem_write controls;
// addr byte address (bits[1:0] ignored); wdata store data; rdata registered
// load data; led/digi peripheral registers; irq timer interrupt.
module mem_stage_dmem
  import mem_stage_dmem_pkg::*;
#(
  parameter int          RAM_DEPTH = 256,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [31:0]   ram [RAM_DEPTH];
  logic [AW-1:0] ram_idx;
  logic          ram_sel, wr;
  logic [29:0]   mmio_w;                  // word offset into the MMIO window
  logic          sel_th, sel_tl, sel_tcon, sel_led, sel_digi, sel_tick;
  logic [31:0]   th, tl, systick, rd_val, rdata_q, rdata_d;
  logic [2:0]    tcon;
  logic [7:0]    led_q, led_d;
  logic [11:0]   digi_q, digi_d;

  assign ram_idx = addr[AW+1:2];
  assign ram_sel = ram_hit(addr, RAM_DEPTH);
  // Addresses below the base wrap to huge offsets and match nothing
  assign mmio_w  = addr[31:2] - MMIO_BASE[31:2];

  assign sel_th   = !ram_sel && mmio_w == OFF_TH[31:2];
  assign sel_tl   = !ram_sel && mmio_w == OFF_TL[31:2];
  assign sel_tcon = !ram_sel && mmio_w == OFF_TCON[31:2];
  assign sel_led  = !ram_sel && mmio_w == OFF_LED[31:2];
  assign sel_digi = !ram_sel && mmio_w == OFF_DIGI[31:2];
  assign sel_tick = !ram_sel && mmio_w == OFF_SYSTICK[31:2];

  // Reset swallows any store in flight
  assign wr = mem_write & ~reset;

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .we_th_i   (wr & sel_th),
    .we_tl_i   (wr & sel_tl),
    .we_tcon_i (wr & sel_tcon),
    .wdata_i   (wdata),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .systick_o (systick),
    .irq_o     (irq)
  );

  always_comb begin
    rd_val = '0;
    if (ram_sel)       rd_val = ram[ram_idx];
    else if (sel_th)   rd_val = th;
    else if (sel_tl)   rd_val = tl;
    else if (sel_tcon) rd_val = {29'd0, tcon};
    else if (sel_led)  rd_val = {24'd0, led_q};
    else if (sel_digi) rd_val = {20'd0, digi_q};
    else if (sel_tick) rd_val = systick;

    rdata_d = mem_read ? rd_val : rdata_q;
    led_d   = (wr && sel_led)  ? wdata[7:0]  : led_q;
    digi_d  = (wr && sel_digi) ? wdata[11:0] : digi_q;
  end

  // RAM is not reset; nonblocking write gives read-first on same-address R/W
  always_ff @(posedge clk) begin
    if (wr && ram_sel) ram[ram_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      led_q   <= '0;
      digi_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      digi_q  <= digi_d;
    end
  end

  assign rdata = rdata_q;
  assign led   = led_q;
  assign digi  = digi_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
module tb_mem_stage_dmem;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int vecs = 0;
  int errs = 0;

  mem_stage_dmem dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .led(led), .digi(digi), .irq(irq)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive at negedge, return 1ns after the capturing edge
  task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read = r; mem_write = w; addr = a; wdata = d;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    vecs++; if (led !== 8'h0)    begin errs++; $display("FAIL rst_led got=%h exp=0", led); end
    vecs++; if (digi !== 12'h0)  begin errs++; $display("FAIL rst_digi got=%h exp=0", digi); end
    vecs++; if (irq !== 1'b0)    begin errs++; $display("FAIL rst_irq got=%b exp=0", irq); end
    @(negedge clk); reset = 1'b0;
    op(1, 0, A_TL, 0);
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_tl got=%h exp=0", rdata); end
    op(1, 0, A_TCON, 0);
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_tcon got=%h exp=0", rdata); end
  endtask

  task automatic test_ram;
    op(0, 1, 32'h10, 32'hDEAD_BEEF);
    op(1, 0, 32'h10, 0);
    vecs++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ram_rd got=%h exp=deadbeef", rdata); end
    op(1, 0, 32'h13, 0);
    vecs++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ram_lowbits got=%h exp=deadbeef", rdata); end
    // Top word, and just past the end (must neither store nor alias word 0)
    op(0, 1, 32'h0, 32'h11);
    op(0, 1, 32'h3FC, 32'h3FC0_0001);
    op(0, 1, 32'h400, 32'h77);
    op(1, 0, 32'h3FC, 0);
    vecs++; if (rdata !== 32'h3FC0_0001) begin errs++; $display("FAIL ram_top got=%h exp=3fc00001", rdata); end
    op(1, 0, 32'h400, 0);
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL ram_past_end got=%h exp=0", rdata); end
    op(1, 0, 32'h0, 0);
    vecs++; if (rdata !== 32'h11) begin errs++; $display("FAIL ram_no_alias got=%h exp=11", rdata); end
  endtask

  task automatic test_read_first;
    op(0, 1, 32'h20, 32'd5);
    op(1, 1, 32'h20, 32'd9);
    vecs++; if (rdata !== 32'd5) begin errs++; $display("FAIL rf_old got=%h exp=5", rdata); end
    op(1, 0, 32'h20, 0);
    vecs++; if (rdata !== 32'd9) begin errs++; $display("FAIL rf_new got=%h exp=9", rdata); end
    op(0, 0, 32'h10, 0);
    op(0, 0, 32'h10, 0);
    vecs++; if (rdata !== 32'd9) begin errs++; $display("FAIL rf_hold got=%h exp=9", rdata); end
  endtask

  task automatic test_timer;
    op(0, 1, A_TH, 32'hFFFF_FFFD);
    op(0, 1, A_TL, 32'hFFFF_FFFE);
    op(0, 1, A_TCON, 32'd3);
    op(1, 0, A_TL, 0);
    vecs++; if (rdata !== 32'hFFFF_FFFE) begin errs++; $display("FAIL tmr_tl0 got=%h exp=fffffffe", rdata); end
    vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL tmr_irq_early got=%b exp=0", irq); end
    op(1, 0, A_TL, 0);          // this edge ends the overflow cycle
    vecs++; if (rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL tmr_tl1 got=%h exp=ffffffff", rdata); end
    vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL tmr_irq_rise got=%b exp=1", irq); end
    op(1, 0, A_TL, 0);
    vecs++; if (rdata !== 32'hFFFF_FFFD) begin errs++; $display("FAIL tmr_reload got=%h exp=fffffffd", rdata); end
    op(0, 1, A_TCON, 32'd3);
    vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL tmr_irq_clr got=%b exp=0", irq); end
    op(0, 1, A_TCON, 32'd0);
    op(0, 1, A_TCON, 32'd0);
  endtask

  task automatic test_collision;
    op(0, 1, A_TL, 32'hFFFF_FFFE);
    op(0, 1, A_TCON, 32'd3);
    op(1, 0, A_TL, 0);
    vecs++; if (rdata !== 32'hFFFF_FFFE) begin errs++; $display("FAIL col_pre got=%h exp=fffffffe", rdata); end
    op(0, 1, A_TL, 32'h100);    // overflow cycle
    vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL col_tl_irq got=%b exp=1", irq); end
    op(1, 0, A_TL, 0);
    vecs++; if (rdata !== 32'h100) begin errs++; $display("FAIL col_tl got=%h exp=100", rdata); end
    op(1, 0, A_TCON, 0);
    vecs++; if (rdata !== 32'd7) begin errs++; $display("FAIL col_tl_tcon got=%h exp=7", rdata); end
    op(0, 1, A_TCON, 32'd0);
    op(0, 1, A_TL, 32'hFFFF_FFFF);
    op(0, 1, A_TCON, 32'd3);
    op(0, 1, A_TCON, 32'd3);    // overflow cycle: IS must survive the write
    vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL col_tcon_irq got=%b exp=1", irq); end
    op(1, 0, A_TCON, 0);
    vecs++; if (rdata !== 32'd7) begin errs++; $display("FAIL col_tcon got=%h exp=7", rdata); end
    op(1, 0, A_TL, 0);
    vecs++; if (rdata !== 32'hFFFF_FFFE) begin errs++; $display("FAIL col_tcon_tl got=%h exp=fffffffe", rdata); end
    op(0, 1, A_TCON, 32'd0);
    op(0, 1, A_TCON, 32'd0);
  endtask

  task automatic test_periph;
    logic [31:0] t0, t1;
    op(0, 1, A_LED, 32'h1A5);
    vecs++; if (led !== 8'hA5) begin errs++; $display("FAIL led got=%h exp=a5", led); end
    op(0, 1, A_DIGI, 32'hFFFF);
    vecs++; if (digi !== 12'hFFF) begin errs++; $display("FAIL digi got=%h exp=fff", digi); end
    op(1, 0, A_LED, 0);
    vecs++; if (rdata !== 32'hA5) begin errs++; $display("FAIL led_rd got=%h exp=a5", rdata); end
    op(1, 0, A_DIGI, 0);
    vecs++; if (rdata !== 32'hFFF) begin errs++; $display("FAIL digi_rd got=%h exp=fff", rdata); end
    op(1, 0, A_TICK, 0); t0 = rdata;
    op(0, 1, A_TICK, 32'h0);
    op(1, 0, A_TICK, 0); t1 = rdata;
    vecs++; if (t1 - t0 !== 32'd2) begin errs++; $display("FAIL systick_gap got=%0d exp=2", t1 - t0); end
    op(1, 0, 32'h5000_0000, 0);
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL unmapped got=%h exp=0", rdata); end
    op(1, 0, A_TICK, 0);
    op(1, 0, 32'h4000_0018, 0);
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL unmapped_win got=%h exp=0", rdata); end
  endtask

  task automatic test_reset_mid;
    op(0, 1, A_TCON, 32'd7);
    vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL rm_pre_irq got=%b exp=1", irq); end
    op(0, 1, A_LED, 32'hFF);
    op(1, 0, 32'h10, 0);
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b1; addr = 32'h10; wdata = 32'h1234;
    @(posedge clk); #1;
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rm_rdata got=%h exp=0", rdata); end
    vecs++; if (led !== 8'h0)    begin errs++; $display("FAIL rm_led got=%h exp=0", led); end
    vecs++; if (digi !== 12'h0)  begin errs++; $display("FAIL rm_digi got=%h exp=0", digi); end
    vecs++; if (irq !== 1'b0)    begin errs++; $display("FAIL rm_irq got=%b exp=0", irq); end
    op(1, 0, A_TL, 0);
    op(1, 0, A_TL, 0);
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rm_tl got=%h exp=0", rdata); end
    op(1, 0, 32'h10, 0);
    vecs++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rm_ram got=%h exp=deadbeef", rdata); end
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    test_reset;
    test_ram;
    test_read_first;
    test_timer;
    test_collision;
    test_periph;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vecs=%0d", vecs);
    $fatal(1);
  end

endmodule
